// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. A single 32-iteration datapath is
// shared by shift-add multiply and restoring divide. Signed ops run on
// operand magnitudes, and the result signs are applied in FIX.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wd,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned W    = 32;
   localparam int unsigned CW   = 5;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t          state;
   logic            is_div;     // latched op[1]
   logic            neg_res;    // negate product / quotient
   logic            neg_rem;    // negate remainder
   logic            b_zero;     // divisor was zero at issue
   logic [W-1:0]    a_raw;      // raw dividend for divide-by-zero HI
   logic [W-1:0]    m_reg;      // multiplicand (mul) or divisor (div)
   logic [W-1:0]    q_reg;      // multiplier (mul) or dividend/quotient (div)
   logic [2*W-1:0]  acc;        // product (mul); remainder in [63:32] (div)
   logic [CW-1:0]   cnt;

   logic            op_signed;
   logic [W-1:0]    a_mag;
   logic [W-1:0]    b_mag;
   logic [W:0]      mul_sum;
   logic [W:0]      div_sh;
   logic [W:0]      div_diff;
   logic [2*W-1:0]  prod_fix;
   logic [W-1:0]    quot_fix;
   logic [W-1:0]    rem_fix;

   // Operand magnitudes, one iteration step and sign fix-up
   always_comb begin
      op_signed = ~op[0];
      a_mag     = (op_signed && a[W-1]) ? W'(-a) : a;
      b_mag     = (op_signed && b[W-1]) ? W'(-b) : b;
      mul_sum   = {1'b0, acc[2*W-1:W]} + (q_reg[0] ? {1'b0, m_reg} : (W+1)'(0));
      div_sh    = {acc[2*W-1:W], q_reg[W-1]};
      div_diff  = div_sh - {1'b0, m_reg};
      prod_fix  = neg_res ? (2*W)'(-acc) : acc;
      quot_fix  = neg_res ? W'(-q_reg) : q_reg;
      rem_fix   = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
   end

   // Control FSM, iteration datapath and HI/LO architectural registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         a_raw   <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         acc     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi <= wd;
               if (lo_we) lo <= wd;
               if (start) begin
                  is_div  <= op[1];
                  m_reg   <= op[1] ? b_mag : a_mag;
                  q_reg   <= op[1] ? a_mag : b_mag;
                  neg_res <= op_signed & (a[W-1] ^ b[W-1]);
                  neg_rem <= op_signed & a[W-1];
                  b_zero  <= (b == '0);
                  a_raw   <= a;
                  acc     <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (is_div) begin
                  if (!div_diff[W]) begin
                     acc[2*W-1:W] <= div_diff[W-1:0];
                     q_reg        <= {q_reg[W-2:0], 1'b1};
                  end else begin
                     acc[2*W-1:W] <= div_sh[W-1:0];
                     q_reg        <= {q_reg[W-2:0], 1'b0};
                  end
               end else begin
                  acc   <= {mul_sum, acc[W-1:1]};
                  q_reg <= {1'b0, q_reg[W-1:1]};
               end
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               if (!is_div) begin
                  hi <= prod_fix[2*W-1:W];
                  lo <= prod_fix[W-1:0];
               end else if (b_zero) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wd;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int passed;
   int total;

   mult_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wd    (wd),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
   function automatic void model(input logic [1:0] mop, input logic [31:0] ma,
                                 input logic [31:0] mb,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint          sa, sb, sq, sr;
      longint unsigned up;
      logic [63:0]     p;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      case (mop)
         2'd0: begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
         end
         2'd1: begin
            up = longint'({32'd0, ma}) * longint'({32'd0, mb});
            p  = 64'(up);
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (mb == 32'd0) begin
               eh = ma;
               el = 32'hFFFF_FFFF;
            end else if (mop == 2'd2) begin
               sq = sa / sb;
               sr = sa % sb;
               p  = 64'(sq);
               el = p[31:0];
               p  = 64'(sr);
               eh = p[31:0];
            end else begin
               el = ma / mb;
               eh = ma % mb;
            end
         end
      endcase
   endfunction

   // Issue one op; returns cycles from start edge to done and busy-cycle count
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom_range(0, 3));
      lat   = -1;
      bcnt  = 0;
      for (int i = 1; i <= 60; i++) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
      total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_multu_max();
      int lat, bcnt;
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      total++; if (lat != 33) $display("FAIL multu_latency: got %0d want 33", lat); else passed++;
      total++; if (bcnt != 33) $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL multu_busy_at_done: got %b want 0", busy); else passed++;
      total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else passed++;
      total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", lo); else passed++;
      @(posedge clk);
      #1;
      total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      do_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
      total++; if (lat != 33) $display("FAIL mult_latency: got %0d want 33", lat); else passed++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else passed++;
      total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo: got %h want fffffff1", lo); else passed++;
      do_op(2'd1, 32'd7, 32'd6, lat, bcnt);
      total++; if (lat != 33) $display("FAIL b2b_latency: got %0d want 33", lat); else passed++;
      total++; if (hi !== 32'd0) $display("FAIL b2b_hi: got %h want 0", hi); else passed++;
      total++; if (lo !== 32'd42) $display("FAIL b2b_lo: got %h want 2a", lo); else passed++;
   endtask

   task automatic test_divide();
      logic [1:0]  ops [5] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd2};
      logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FF00};
      logic [31:0] bs  [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd16, 32'd0};
      logic [31:0] ehs [5] = '{32'hFFFF_FFFF, 32'd0, 32'd100, 32'hF, 32'hFFFF_FF00};
      logic [31:0] els [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hFFFF_FFFF};
      int lat, bcnt;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], lat, bcnt);
         total++; if (lat != 33) $display("FAIL div%0d_latency: got %0d want 33", i, lat); else passed++;
         total++; if (hi !== ehs[i]) $display("FAIL div%0d_hi: got %h want %h", i, hi, ehs[i]); else passed++;
         total++; if (lo !== els[i]) $display("FAIL div%0d_lo: got %h want %h", i, lo, els[i]); else passed++;
      end
   endtask

   task automatic test_mt_write();
      logic [31:0] lo_prev;
      int lat;
      lo_prev = lo;
      hi_we = 1'b1; wd = 32'h1234;
      @(posedge clk); #1;
      hi_we = 1'b0;
      total++; if (hi !== 32'h1234) $display("FAIL mthi_hi: got %h want 00001234", hi); else passed++;
      total++; if (lo !== lo_prev) $display("FAIL mthi_lo_kept: got %h want %h", lo, lo_prev); else passed++;
      lo_we = 1'b1; wd = 32'h5678;
      @(posedge clk); #1;
      lo_we = 1'b0;
      total++; if (lo !== 32'h5678) $display("FAIL mtlo_lo: got %h want 00005678", lo); else passed++;
      total++; if (hi !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); else passed++;
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      total++; if ({hi, lo} !== {32'hCAFE, 32'hCAFE}) $display("FAIL mt_both: got %h_%h want 0000cafe_0000cafe", hi, lo); else passed++;
      // MT write in the same cycle as start: write lands, op result overwrites later
      hi_we = 1'b1; wd = 32'hBEEF; start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
      @(posedge clk); #1;
      hi_we = 1'b0; start = 1'b0;
      total++; if (hi !== 32'hBEEF) $display("FAIL mt_with_start_hi: got %h want 0000beef", hi); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL mt_with_start_busy: got %b want 1", busy); else passed++;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
      total++; if (lat != 33) $display("FAIL mt_with_start_latency: got %0d want 33", lat); else passed++;
      total++; if ({hi, lo} !== {32'd0, 32'd6}) $display("FAIL mt_with_start_result: got %h_%h want 00000000_00000006", hi, lo); else passed++;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] hi0, lo0, eh, el;
      int lat, bad;
      hi0 = hi; lo0 = lo; bad = 0;
      model(2'd1, 32'h0012_3456, 32'h0000_0777, eh, el);
      start = 1'b1; op = 2'd1; a = 32'h0012_3456; b = 32'h0000_0777;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         if (i == 5) begin
            hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
            start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
         end else begin
            hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
         if (hi !== hi0 || lo !== lo0) bad++;
      end
      hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
      total++; if (bad != 0) $display("FAIL busy_hold_hilo: got %0d changed cycles want 0", bad); else passed++;
      total++; if (lat != 33) $display("FAIL busy_ignore_latency: got %0d want 33", lat); else passed++;
      total++; if ({hi, lo} !== {eh, el}) $display("FAIL busy_ignore_result: got %h_%h want %h_%h", hi, lo, eh, el); else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) $display("FAIL busy_ignore_no_second_op: got %b want 0", busy); else passed++;
   endtask

   task automatic test_reset_midrun();
      int lat, bcnt;
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'hAAAA_5555;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL midrun_reset_done: got %b want 0", done); else passed++;
      total++; if ({hi, lo} !== 64'd0) $display("FAIL midrun_reset_hilo: got %h_%h want 0_0", hi, lo); else passed++;
      rst_n = 1'b1;
      do_op(2'd3, 32'd9, 32'd3, lat, bcnt);
      total++; if (lat != 33) $display("FAIL restart_latency: got %0d want 33", lat); else passed++;
      total++; if ({hi, lo} !== {32'd0, 32'd3}) $display("FAIL restart_result: got %h_%h want 00000000_00000003", hi, lo); else passed++;
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] x, y, eh, el;
      int lat, bcnt;
      for (int n = 0; n < 40; n++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: begin x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(1, 15)); end
            3: y = 32'($urandom_range(1, 1000)) * (($urandom & 1) != 0 ? 32'hFFFF_FFFF : 32'd1);
            default: ;
         endcase
         model(o, x, y, eh, el);
         do_op(o, x, y, lat, bcnt);
         total++; if (lat != 33) $display("FAIL rand%0d_latency: got %0d want 33", n, lat); else passed++;
         total++; if (hi !== eh) $display("FAIL rand%0d_hi op=%0d a=%h b=%h: got %h want %h", n, o, x, y, hi, eh); else passed++;
         total++; if (lo !== el) $display("FAIL rand%0d_lo op=%0d a=%h b=%h: got %h want %h", n, o, x, y, lo, el); else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = 2'd0;
      a      = 32'd0;
      b      = 32'd0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      wd     = 32'd0;
      test_reset();
      test_multu_max();
      test_back_to_back();
      test_divide();
      test_mt_write();
      test_busy_ignore();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
